// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master: FSM states, defaults and helpers.
package spi_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SETUP  = 3'd1,
      SCK_HI = 3'd2,
      SCK_LO = 3'd3,
      HOLD   = 3'd4
   } spi_state_t;

   localparam int unsigned SPI_CLK_DIV_DEFAULT = 4;
   localparam int unsigned SPI_BITS            = 8;

   // Width needed to hold CLK_DIV-1 .. 0 for any legal divider.
   function automatic int unsigned cnt_width(input int unsigned div);
      return $clog2(div + 1);
   endfunction

endpackage

// File: rtl/spi_tick_gen.sv
// Half-period down-counter: reloads to CLK_DIV-1 on load and issues a
// one-cycle tick when it has counted down to zero.
module spi_tick_gen
   import spi_pkg::*;
#(
   parameter int unsigned CLK_DIV = SPI_CLK_DIV_DEFAULT
) (
   input  logic clk,
   input  logic reset_n,
   input  logic load,
   input  logic en,
   output logic tick
);

   localparam int unsigned CW = cnt_width(CLK_DIV);

   logic [CW-1:0] cnt;

   // Count down from the reload value and park at zero.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= CW'(CLK_DIV - 1);
      end else if (cnt != '0) begin
         cnt <= cnt - CW'(1);
      end
   end

   assign tick = en && (cnt == '0);

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 master: one 8-bit MSB-first transfer per accepted start,
// with registered sck/mosi/cs_n and a one-cycle done pulse.
module spi_master
   import spi_pkg::*;
#(
   parameter int unsigned CLK_DIV = SPI_CLK_DIV_DEFAULT
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       start,
   input  logic [7:0] tx_data,
   output logic [7:0] rx_data,
   output logic       busy,
   output logic       done,
   output logic       sck,
   output logic       mosi,
   input  logic       miso,
   output logic       cs_n
);

   spi_state_t state;
   logic [6:0] tx_sh;    // remaining tx bits below the one on mosi
   logic [7:0] rx_sh;
   logic [2:0] bit_cnt;  // index of the sck period in progress
   logic       tick;
   logic       load;
   logic       tick_en;

   // Every state change restarts the half-period; in IDLE only an accepted
   // start does, elsewhere every tick moves the FSM on.
   always_comb begin
      load = 1'b0;
      if (state == IDLE) begin
         load = start;
      end else begin
         load = tick;
      end
   end

   assign tick_en = (state != IDLE);

   spi_tick_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_tick (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (load),
      .en      (tick_en),
      .tick    (tick)
   );

   // Transfer FSM with registered SPI pins, shift registers and status.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         tx_sh   <= '0;
         rx_sh   <= '0;
         bit_cnt <= '0;
         rx_data <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         sck     <= 1'b0;
         mosi    <= 1'b0;
         cs_n    <= 1'b1;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               sck  <= 1'b0;
               cs_n <= 1'b1;
               mosi <= 1'b0;
               if (start) begin
                  tx_sh   <= tx_data[6:0];
                  mosi    <= tx_data[7];
                  cs_n    <= 1'b0;
                  busy    <= 1'b1;
                  bit_cnt <= '0;
                  state   <= SETUP;
               end
            end
            SETUP, SCK_LO: begin
               if (tick) begin
                  sck   <= 1'b1;
                  rx_sh <= {rx_sh[6:0], miso};
                  state <= SCK_HI;
               end
            end
            SCK_HI: begin
               if (tick) begin
                  sck <= 1'b0;
                  // mosi keeps bit 0 through HOLD after the last fall
                  if (bit_cnt == 3'(SPI_BITS - 1)) begin
                     state <= HOLD;
                  end else begin
                     bit_cnt <= bit_cnt + 3'd1;
                     mosi    <= tx_sh[6];
                     tx_sh   <= {tx_sh[5:0], 1'b0};
                     state   <= SCK_LO;
                  end
               end
            end
            HOLD: begin
               if (tick) begin
                  cs_n    <= 1'b1;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  mosi    <= 1'b0;
                  rx_data <= rx_sh;
                  bit_cnt <= '0;
                  state   <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: clk cycles per sck half-period; legal range 1..255.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on posedge clk.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port start  input  1  request one 8-bit transfer; sampled only in IDLE.
REQ-005 SHALL have port tx_data  input  8  byte to send, MSB first; latched when start is accepted.
REQ-006 SHALL have port rx_data  output  8  last byte received, MSB first.
REQ-007 SHALL have port busy  output  1  transfer in progress.
REQ-008 SHALL have port done  output  1  one-cycle pulse; rx_data is valid from this cycle.
REQ-009 SHALL have port sck  output  1  SPI clock, idle low (mode 0), registered.
REQ-010 SHALL have port mosi  output  1  serial data to slave, registered.
REQ-011 SHALL have port miso  input  1  serial data from slave.
REQ-012 SHALL have port cs_n  output  1  slave select, active low, registered.

Function
REQ-013 SHALL implement FSM states IDLE, SETUP, SCK_HI, SCK_LO, HOLD.
REQ-014 Start acceptance (cycle 0 = clk edge sampling start=1 in IDLE): SHALL latch tx_data and enter SETUP; from cycle 1, cs_n=0, busy=1, mosi=tx_data[7].
REQ-015 SETUP SHALL last CLK_DIV cycles, then raise sck (first rise at cycle 1+CLK_DIV).
REQ-016 SHALL toggle sck every CLK_DIV cycles for exactly 16 edges (8 rises, 8 falls); last fall at cycle 1+16*CLK_DIV.
REQ-017 SHALL sample miso into bit 0 of the receive shift register at the clk edge that drives sck 0->1.
REQ-018 SHALL advance mosi to the next lower tx bit at the clk edge that drives sck 1->0, except after the 8th fall.
REQ-019 HOLD SHALL last CLK_DIV cycles with sck=0 and cs_n=0, then enter IDLE.
REQ-020 At cycle 1+17*CLK_DIV: cs_n=1, busy=0, done=1 for one cycle, rx_data updated with all 8 received bits.
REQ-021 rx_data SHALL change only at that done cycle; it holds its value otherwise.
REQ-022 start while busy=1 SHALL be ignored; start=1 in the done cycle SHALL be accepted (back-to-back).
REQ-023 The half-period counter SHALL be ceil(log2(CLK_DIV+1)) bits wide, count CLK_DIV-1 down to 0, and reload on every state/edge transition.
REQ-024 In IDLE: sck=0, cs_n=1, mosi=0.

Reset
REQ-025 reset_n=0 SHALL immediately force state=IDLE, sck=0, cs_n=1, mosi=0, busy=0, done=0, rx_data=0, counter=0.
REQ-026 Reset mid-transfer SHALL abort with no done pulse; after release, the next start SHALL perform a full normal transfer.

Structure
REQ-027 Shared package spi_pkg SHALL hold the FSM state enum, the CLK_DIV default, and SPI_BITS=8.
REQ-028 One sub-module, spi_tick_gen (half-period down-counter issuing a one-cycle tick), SHALL be used; the FSM and shift registers SHALL stay in spi_master.

Verification
REQ-029 Loopback (miso tied to mosi), CLK_DIV=4, tx 0xA5 -> done at cycle 69, rx_data=0xA5, 8 sck rises observed.
REQ-030 Against spi_slave model with d=0x3C, tx 0xC3 -> master rx_data=0x3C, slave q=0xC3.
REQ-031 Back-to-back: start held high, tx 0x01 then 0x80 -> two done pulses 69 cycles apart, cs_n high for exactly one cycle between.
REQ-032 start pulsed at cycle 20 of a transfer -> ignored; exactly one done pulse.
REQ-033 reset_n low at cycle 30 -> sck=0, cs_n=1, busy=0 asynchronously, no done; next transfer of 0x5A returns 0x5A.
REQ-034 CLK_DIV=1, loopback tx 0xFF -> done at cycle 18, sck toggles every clk cycle.
